// File: rtl/morph_filter_1d_if.sv
// morph_filter_1d_if: stream, mode and kernel-write bundle for morph_filter_1d.
//   axis_in_*    : signed sample stream into the filter (tdata/tvalid in, tready out)
//   axis_out_*   : signed result stream out of the filter (tdata/tvalid out, tready in)
//   op_mode      : 0 = erosion, 1 = dilation, captured with each accepted sample
//   soft_clear   : empties the sample window while the filter is idle
//   kernel_wr_*  : coefficient write port (en/addr/data in, ready out)
// Modports: slave = filter side, master = source/controller side.
interface morph_filter_1d_if #(
    parameter int DATA_WIDTH        = 16,
    parameter int KERNEL_WIDTH      = 71,
    parameter int KERNEL_DATA_WIDTH = 8
);
    localparam int AW = $clog2(KERNEL_WIDTH);
    logic signed [DATA_WIDTH-1:0]        axis_in_tdata;
    logic                                axis_in_tvalid;
    logic                                axis_in_tready;
    logic signed [DATA_WIDTH-1:0]        axis_out_tdata;
    logic                                axis_out_tvalid;
    logic                                axis_out_tready;
    logic                                op_mode;
    logic                                soft_clear;
    logic                                kernel_wr_en;
    logic [AW-1:0]                       kernel_wr_addr;
    logic signed [KERNEL_DATA_WIDTH-1:0] kernel_wr_data;
    logic                                kernel_wr_ready;
    modport slave (
        input  axis_in_tdata, axis_in_tvalid, axis_out_tready,
        input  op_mode, soft_clear, kernel_wr_en, kernel_wr_addr, kernel_wr_data,
        output axis_in_tready, axis_out_tdata, axis_out_tvalid, kernel_wr_ready
    );
    modport master (
        output axis_in_tdata, axis_in_tvalid, axis_out_tready,
        output op_mode, soft_clear, kernel_wr_en, kernel_wr_addr, kernel_wr_data,
        input  axis_in_tready, axis_out_tdata, axis_out_tvalid, kernel_wr_ready
    );
endinterface

// File: rtl/morph_filter_1d.sv
// morph_filter_1d: 1-D grayscale erosion/dilation over the last KERNEL_WIDTH samples.
//   clk      : clock
//   areset_n : asynchronous active-low reset
//   bus      : morph_filter_1d_if.slave (input/output streams, op_mode, soft_clear,
//              kernel write port)
// Each accepted sample is folded LANES window terms per cycle; unfilled window
// slots are skipped so warm-up outputs only see real samples.
module morph_filter_1d #(
    parameter int DATA_WIDTH        = 16,
    parameter int KERNEL_WIDTH      = 71,
    parameter int KERNEL_DATA_WIDTH = 8,
    parameter int LANES             = 4
) (
    input logic           clk,
    input logic           areset_n,
    morph_filter_1d_if.slave bus
);
    localparam int M  = KERNEL_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int AW = $clog2(M);
    localparam int FW = $clog2(M + 1);
    localparam int C  = (M + LANES - 1) / LANES;
    localparam int BW = $clog2(C + 1);
    localparam int SW = (DW > KERNEL_DATA_WIDTH ? DW : KERNEL_DATA_WIDTH) + 1;
    localparam logic signed [DW-1:0] POS_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] NEG_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t                              state_q, state_d;
    logic signed [DW-1:0]                buf_q [M];
    logic signed [KERNEL_DATA_WIDTH-1:0] kern_q [M];
    logic [AW-1:0]                       ptr_q;
    logic [FW-1:0]                       fill_q;
    logic [BW-1:0]                       beat_q, beat_d;
    logic signed [DW-1:0]                acc_q, acc_d, tdata_q, tdata_d, lane_acc;
    logic                                mode_q;
    logic                                idle, in_hs, k_wr;

    assign idle                = state_q == IDLE;
    assign in_hs               = idle && bus.axis_in_tvalid;
    assign k_wr                = idle && bus.kernel_wr_en && int'(bus.kernel_wr_addr) < M;
    assign bus.axis_in_tready  = idle;
    assign bus.kernel_wr_ready = idle;
    assign bus.axis_out_tvalid = state_q == OUT;
    assign bus.axis_out_tdata  = tdata_q;

    // ptr_q points at the oldest slot once the newest sample is written, so
    // window index j maps to ring slot (ptr_q + j) mod M.
    always_comb begin
        int j, idx;
        logic signed [KERNEL_DATA_WIDTH-1:0] kc;
        logic signed [SW-1:0] sum;
        logic signed [DW-1:0] term;
        lane_acc = acc_q;
        j = 0;
        idx = 0;
        kc = '0;
        sum = '0;
        term = '0;
        for (int l = 0; l < LANES; l++) begin
            j = int'(beat_q) * LANES + l;
            if (j < M && j >= M - int'(fill_q)) begin
                idx = int'(ptr_q) + j;
                idx = idx >= M ? idx - M : idx;
                kc = mode_q ? kern_q[AW'(M - 1 - j)] : kern_q[AW'(j)];
                sum = SW'(buf_q[AW'(idx)]) + SW'(kc);
                term = sum > SW'(POS_MAX) ? POS_MAX : sum < SW'(NEG_MIN) ? NEG_MIN : DW'(sum);
                lane_acc = mode_q ? (term > lane_acc ? term : lane_acc)
                                  : (term < lane_acc ? term : lane_acc);
            end
        end
    end

    // Beats 0..C-1 fold window terms; the extra beat C moves the result into
    // the output register.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        acc_d   = acc_q;
        tdata_d = tdata_q;
        case (state_q)
            IDLE: if (in_hs) begin
                state_d = CALC;
                beat_d  = '0;
                acc_d   = bus.op_mode ? NEG_MIN : POS_MAX;
            end
            CALC: begin
                acc_d  = lane_acc;
                beat_d = beat_q + 1'b1;
                if (beat_q == BW'(C)) begin
                    state_d = OUT;
                    tdata_d = acc_q;
                end
            end
            OUT: if (bus.axis_out_tready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            acc_q   <= '0;
            tdata_q <= '0;
            mode_q  <= 1'b0;
            ptr_q   <= '0;
            fill_q  <= '0;
            for (int i = 0; i < M; i++) kern_q[i] <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            acc_q   <= acc_d;
            tdata_q <= tdata_d;
            if (in_hs) begin
                ptr_q  <= ptr_q == AW'(M - 1) ? '0 : ptr_q + 1'b1;
                fill_q <= bus.soft_clear ? FW'(1) : fill_q == FW'(M) ? fill_q : fill_q + 1'b1;
                mode_q <= bus.op_mode;
            end else if (idle && bus.soft_clear) begin
                fill_q <= '0;
            end
            if (k_wr) kern_q[bus.kernel_wr_addr] <= bus.kernel_wr_data;
        end
    end

    // Sample storage needs no reset: fill_q decides which slots are read.
    always_ff @(posedge clk) begin
        if (in_hs) buf_q[ptr_q] <= bus.axis_in_tdata;
    end
endmodule

// File: tb/tb_morph_filter_1d.sv
// tb_morph_filter_1d: directed and randomized checks of morph_filter_1d against
// a sample-history model (M=5, LANES=2).
module tb_morph_filter_1d;
    localparam int DW = 16, M = 5, KDW = 8, LANES = 2;
    localparam int AW = $clog2(M), C = (M + LANES - 1) / LANES;
    localparam int HI = (1 << (DW - 1)) - 1, LO = -(1 << (DW - 1));

    logic clk = 1'b0;
    logic areset_n = 1'b1;
    int errors = 0, checks = 0;
    int hist[$];
    int km[M];

    always #5 clk = ~clk;

    morph_filter_1d_if #(.DATA_WIDTH(DW), .KERNEL_WIDTH(M), .KERNEL_DATA_WIDTH(KDW)) bus ();
    morph_filter_1d #(.DATA_WIDTH(DW), .KERNEL_WIDTH(M), .KERNEL_DATA_WIDTH(KDW), .LANES(LANES)) dut (
        .clk(clk),
        .areset_n(areset_n),
        .bus(bus)
    );

    function automatic int sat(input int v);
        return v > HI ? HI : v < LO ? LO : v;
    endfunction

    // age 0 is the newest sample (window index M-1).
    function automatic int model(input bit dil);
        int y, t;
        y = dil ? LO : HI;
        for (int age = 0; age < hist.size(); age++) begin
            t = sat(hist[hist.size() - 1 - age] + (dil ? km[age] : km[M - 1 - age]));
            if (dil ? t > y : t < y) y = t;
        end
        return y;
    endfunction

    task automatic send(input int d, input bit dil, input bit clr, output bit ok);
        bus.axis_in_tdata = DW'(d);
        bus.axis_in_tvalid = 1'b1;
        bus.op_mode = dil;
        bus.soft_clear = clr;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            ok = bus.axis_in_tready;
            @(posedge clk);
            #1;
        end
        bus.axis_in_tvalid = 1'b0;
        bus.soft_clear = 1'b0;
        bus.op_mode = ~dil;
        if (ok) begin
            if (clr) hist.delete();
            hist.push_back(d);
            if (hist.size() > M) void'(hist.pop_front());
        end
    endtask

    task automatic get_out(output int got, output int lat);
        lat = -1;
        got = 0;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            if (bus.axis_out_tvalid) begin
                lat = n;
                got = int'(bus.axis_out_tdata);
                break;
            end
        end
    endtask

    task automatic xfer(input int d, input bit dil, input bit clr, input int stall, output int got, output int lat);
        bit ok;
        bus.axis_out_tready = stall == 0;
        send(d, dil, clr, ok);
        got = 0;
        lat = -1;
        if (ok) get_out(got, lat);
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        bus.axis_out_tready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_kernel(input int a, input int v, input bit lands);
        bus.kernel_wr_en = 1'b1;
        bus.kernel_wr_addr = AW'(a);
        bus.kernel_wr_data = KDW'(v);
        @(posedge clk);
        #1;
        bus.kernel_wr_en = 1'b0;
        if (lands) km[a] = v;
    endtask

    task automatic clear_window;
        bus.soft_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.soft_clear = 1'b0;
        hist.delete();
    endtask

    task automatic test_reset;
        areset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.axis_in_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %0b want 1", bus.axis_in_tready); end
        checks++;
        if (bus.axis_out_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b want 0", bus.axis_out_tvalid); end
        checks++;
        if (bus.axis_out_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %0d want 0", bus.axis_out_tdata); end
        checks++;
        if (bus.kernel_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_kwr_ready: got %0b want 1", bus.kernel_wr_ready); end
        areset_n = 1'b1;
        hist.delete();
        km = '{default: 0};
        @(posedge clk);
        #1;
    endtask

    task automatic test_erosion;
        int xs[7] = '{10, 3, 7, 9, 8, 12, 20};
        int ex[7] = '{10, 3, 3, 3, 3, 3, 7};
        int got, lat;
        for (int i = 0; i < 7; i++) begin
            xfer(xs[i], 1'b0, 1'b0, 0, got, lat);
            checks++;
            if (lat < 0 || got !== ex[i]) begin errors++; $display("FAIL erosion[%0d]: got %0d (lat %0d) want %0d", i, got, lat, ex[i]); end
            if (i == 0) begin
                checks++;
                if (lat !== C + 1) begin errors++; $display("FAIL latency: got %0d want %0d", lat, C + 1); end
            end
        end
    endtask

    task automatic test_dilation;
        int xs[7] = '{10, 3, 7, 9, 8, 12, 20};
        int ex[7] = '{10, 10, 10, 10, 10, 12, 20};
        int got, lat;
        clear_window();
        for (int i = 0; i < 7; i++) begin
            xfer(xs[i], 1'b1, 1'b0, 0, got, lat);
            checks++;
            if (lat < 0 || got !== ex[i]) begin errors++; $display("FAIL dilation[%0d]: got %0d (lat %0d) want %0d", i, got, lat, ex[i]); end
        end
        wr_kernel(0, 5, 1'b1);
        xfer(1, 1'b1, 1'b0, 0, got, lat);
        checks++;
        if (lat < 0 || got !== 20) begin errors++; $display("FAIL dilation_k0: got %0d want 20", got); end
        clear_window();
        xfer(1, 1'b1, 1'b0, 0, got, lat);
        checks++;
        if (lat < 0 || got !== 6) begin errors++; $display("FAIL dilation_reflect: got %0d want 6", got); end
        xfer(1, 1'b0, 1'b0, 0, got, lat);
        checks++;
        if (lat < 0 || got !== 1) begin errors++; $display("FAIL erosion_k4_zero: got %0d want 1", got); end
        wr_kernel(0, 0, 1'b1);
    endtask

    task automatic test_saturation;
        int got, lat;
        clear_window();
        wr_kernel(4, 100, 1'b1);
        xfer(32760, 1'b0, 1'b0, 0, got, lat);
        checks++;
        if (lat < 0 || got !== 32767) begin errors++; $display("FAIL sat_pos: got %0d want 32767", got); end
        clear_window();
        wr_kernel(0, -100, 1'b1);
        xfer(-32768, 1'b1, 1'b0, 0, got, lat);
        checks++;
        if (lat < 0 || got !== -32768) begin errors++; $display("FAIL sat_neg: got %0d want -32768", got); end
        wr_kernel(0, 0, 1'b1);
        wr_kernel(4, 0, 1'b1);
    endtask

    task automatic test_back_to_back;
        bit ok;
        int got, lat;
        clear_window();
        bus.axis_out_tready = 1'b0;
        send(100, 1'b0, 1'b0, ok);
        get_out(got, lat);
        checks++;
        if (!ok || lat < 0 || got !== 100) begin errors++; $display("FAIL bp_first: got %0d (lat %0d) want 100", got, lat); end
        bus.axis_in_tdata = DW'(55);
        bus.axis_in_tvalid = 1'b1;
        bus.op_mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.axis_out_tvalid !== 1'b1 || int'(bus.axis_out_tdata) !== 100 || bus.axis_in_tready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall[%0d]: tvalid=%0b tdata=%0d in_tready=%0b want 1/100/0", i, bus.axis_out_tvalid, bus.axis_out_tdata, bus.axis_in_tready);
            end
        end
        bus.axis_out_tready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.axis_out_tvalid !== 1'b0) begin errors++; $display("FAIL bp_tvalid_fall: got %0b want 0", bus.axis_out_tvalid); end
        send(55, 1'b0, 1'b0, ok);
        get_out(got, lat);
        checks++;
        if (!ok || lat < 0 || got !== 55) begin errors++; $display("FAIL bp_second: got %0d (lat %0d) want 55", got, lat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_calc;
        bit ok;
        int got, lat;
        wr_kernel(4, -20, 1'b1);
        send(77, 1'b0, 1'b0, ok);
        @(posedge clk);
        #1;
        areset_n = 1'b0;
        #1;
        checks++;
        if (bus.axis_out_tvalid !== 1'b0 || bus.axis_in_tready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: tvalid=%0b tready=%0b want 0/1", bus.axis_out_tvalid, bus.axis_in_tready);
        end
        hist.delete();
        km = '{default: 0};
        repeat (2) @(posedge clk);
        #1;
        areset_n = 1'b1;
        for (int i = 0; i < C + 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.axis_out_tvalid !== 1'b0) begin errors++; $display("FAIL phantom_out[%0d]: tvalid=%0b want 0", i, bus.axis_out_tvalid); end
        end
        send(42, 1'b0, 1'b0, ok);
        checks++;
        if (bus.kernel_wr_ready !== 1'b0) begin errors++; $display("FAIL kwr_ready_calc: got %0b want 0", bus.kernel_wr_ready); end
        wr_kernel(4, -50, 1'b0);
        get_out(got, lat);
        checks++;
        if (!ok || lat < 0 || got !== 42) begin errors++; $display("FAIL after_reset: got %0d (lat %0d) want 42", got, lat); end
        @(posedge clk);
        #1;
        xfer(42, 1'b0, 1'b0, 0, got, lat);
        checks++;
        if (lat < 0 || got !== 42) begin errors++; $display("FAIL dropped_kwr: got %0d want 42", got); end
    endtask

    task automatic test_random;
        logic signed [15:0] r16;
        logic signed [7:0] r8;
        int got, lat, exp, d;
        bit dil, clr;
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 7))
                0: clear_window();
                1, 2: begin
                    r8 = 8'($urandom);
                    wr_kernel(int'($urandom_range(0, M - 1)), int'(r8), 1'b1);
                end
                default: ;
            endcase
            r16 = 16'($urandom);
            d = int'(r16);
            dil = 1'($urandom_range(0, 1));
            clr = $urandom_range(0, 7) == 0;
            xfer(d, dil, clr, int'($urandom_range(0, 3)), got, lat);
            exp = model(dil);
            checks++;
            if (lat < 0 || got !== exp) begin errors++; $display("FAIL random[%0d]: got %0d (lat %0d) want %0d", it, got, lat, exp); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.axis_in_tdata = '0;
        bus.axis_in_tvalid = 1'b0;
        bus.axis_out_tready = 1'b1;
        bus.op_mode = 1'b0;
        bus.soft_clear = 1'b0;
        bus.kernel_wr_en = 1'b0;
        bus.kernel_wr_addr = '0;
        bus.kernel_wr_data = '0;
        #1;
        test_reset();
        test_erosion();
        test_dilation();
        test_saturation();
        test_back_to_back();
        test_reset_mid_calc();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
